// File: rtl/tpu_job_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_job_sequencer
//
// Upstream driver for the memory-mapped TPU core. Takes one matmul job as a
// stream of DATAW-bit words (A rows, B rows, then C0 words), replays the job as
// TPU bus writes, fires MatMul, waits MATMUL_WAIT cycles, reads C back and
// emits it as a DATAW-bit result stream. Only one job is in flight at a time.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   in_valid/ready  job word handshake, in_data carries the word
//   out_valid/ready result word handshake, out_data carries the word
//   busy            high while a job is being processed
//   job_done        one-cycle pulse when the last result word is consumed
//   tpu_r_w         TPU bus direction (1 = write, 0 = read)
//   tpu_addr        TPU byte address (8-byte aligned)
//   tpu_dataIn      TPU write data
//   tpu_dataOut     TPU read data, combinational from tpu_addr
//
// Build option
//   TPU_SEQ_CLEAR_C_EN  when defined, a job is A and B only; the C region is
//                       written with zeros so the TPU computes C = A*B.
//                       When undefined, C0 comes from the stream (C = A*B+C0).
// ---------------------------------------------------------------------------
module tpu_job_sequencer #(
  parameter int DIM         = 8,
  parameter int DATAW       = 64,
  parameter int ADDRW       = 16,
  parameter int BITS_C      = 16,
  parameter int MATMUL_WAIT = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             busy,
  output logic             job_done,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  localparam int CW    = DIM * BITS_C / DATAW;
  localparam int NCW   = DIM * CW;
  localparam int CNTW  = $clog2(NCW) + 1;
  localparam int WAITW = $clog2(MATMUL_WAIT) + 1;

  localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE  = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

  localparam logic [CNTW-1:0]  CNT_AB_LAST = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0]  CNT_C_LAST  = CNTW'(NCW - 1);
  localparam logic [WAITW-1:0] WAIT_LAST   = WAITW'(MATMUL_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_C,
    S_START,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WAITW-1:0]   wait_q, wait_d;
  logic               out_valid_q, out_valid_d;
  logic [DATAW-1:0]   out_data_q, out_data_d;
  // Goes high on the first clock after reset release so that in_ready stays
  // low while rst_n is asserted even though IDLE normally accepts words.
  logic               live_q, live_d;

  logic               load_beat;
  logic               capture;
  logic [WAITW-1:0]   wait_inc;
  logic [ADDRW-1:0]   word_off;
  logic [ADDRW-1:0]   load_base;

  assign word_off = ADDRW'(cnt_q) << 3;
  assign wait_inc = wait_q + WAITW'(1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      live_q      <= live_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    live_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        // The accepted word is A row 0, written this same cycle.
        if (load_beat) begin
          state_d = S_LOAD_A;
          cnt_d   = CNTW'(1);
        end
      end

      S_LOAD_A: begin
        if (load_beat) begin
          if (cnt_q == CNT_AB_LAST) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      S_LOAD_B: begin
        if (load_beat) begin
          if (cnt_q == CNT_AB_LAST) begin
            state_d = S_LOAD_C;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      S_LOAD_C: begin
        if (load_beat) begin
          if (cnt_q == CNT_C_LAST) begin
            state_d = S_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      S_START: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end

      S_WAIT: begin
        // Leaving when the incremented count hits MATMUL_WAIT-1 puts the first
        // read exactly MATMUL_WAIT cycles after the MatMul write.
        wait_d = wait_inc;
        if (wait_inc == WAIT_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end

      S_READ: begin
        // A capture may coincide with consumption of the previous word, so
        // out_valid simply stays high and the data register is overwritten.
        if (capture) begin
          out_data_d  = tpu_dataOut;
          out_valid_d = 1'b1;
          if (cnt_q == CNT_C_LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    load_beat  = 1'b0;
    load_base  = A_BASE;
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;

    case (state_q)
      S_IDLE, S_LOAD_A: begin
        in_ready  = live_q;
        load_beat = live_q && in_valid;
        load_base = A_BASE;
      end

      S_LOAD_B: begin
        in_ready  = 1'b1;
        load_beat = in_valid;
        load_base = B_BASE;
      end

      S_LOAD_C: begin
        load_base = C_BASE;
`ifdef TPU_SEQ_CLEAR_C_EN
        load_beat = 1'b1;
`else
        in_ready  = 1'b1;
        load_beat = in_valid;
`endif
      end

      S_START: begin
        tpu_r_w  = 1'b1;
        tpu_addr = MM_ADDR;
      end

      S_READ: begin
        tpu_addr = C_BASE + word_off;
      end

      default: begin
      end
    endcase

    if (load_beat) begin
      tpu_r_w  = 1'b1;
      tpu_addr = load_base + word_off;
`ifdef TPU_SEQ_CLEAR_C_EN
      tpu_dataIn = (state_q == S_LOAD_C) ? '0 : in_data;
`else
      tpu_dataIn = in_data;
`endif
    end
  end

  assign capture   = (state_q == S_READ) && (!out_valid_q || out_ready);
  assign job_done  = (state_q == S_DRAIN) && out_valid_q && out_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
